axis_circular_unpacker: RTL
===========================

Name: axis_circular_unpacker

Overview:
- Read-back side of the circular capture path. After a capture stops, it reads the circular BRAM buffer in chronological order and emits the samples as one AXI4-Stream packet.
- The oldest sample is computed from the recorded trigger position and the requested pre-trigger depth. Addresses wrap modulo buffer depth.
- Sits between the capture BRAM read port and the DMA/host stream path. Reset is asynchronous and active-low.

Parameters:
AXIS_TDATA_WIDTH, 32, width of m_axis_tdata; equals BRAM_DATA_WIDTH
BRAM_DATA_WIDTH, 32, BRAM read data width
BRAM_ADDR_WIDTH, 10, BRAM address width; buffer depth D = 2^BRAM_ADDR_WIDTH words

Ports:
aclk  in  1  clock
aresetn  in  1  asynchronous active-low reset
cfg_trigger_pos  in  BRAM_ADDR_WIDTH  address of the trigger sample (capture's trigger position, truncated)
cfg_pretrigger  in  BRAM_ADDR_WIDTH  number of words to read before the trigger sample
cfg_length  in  BRAM_ADDR_WIDTH+1  total words to emit, 0..D
start  in  1  level-sampled start request
busy  out  1  high while a readout is in progress
done  out  1  one-cycle pulse after the final beat handshake
bram_porta_clk  out  1  equals aclk
bram_porta_rst  out  1  equals ~aresetn
bram_porta_addr  out  BRAM_ADDR_WIDTH  registered read address
bram_porta_rddata  in  BRAM_DATA_WIDTH  read data, valid 1 clock after address is sampled
m_axis_tready  in  1  downstream ready
m_axis_tdata  out  AXIS_TDATA_WIDTH  sample data
m_axis_tvalid  out  1  data valid
m_axis_tlast  out  1  final beat of the packet

Behaviour:
- Reset (asynchronous, any time including mid-readout):
  - State goes to IDLE; output buffer and in-flight tracking are flushed.
  - busy, done, m_axis_tvalid, m_axis_tlast and bram_porta_addr are 0.
  - Any partial packet is abandoned, with no tlast.
- States:
  - IDLE: busy=0. On start=1 at an edge:
    - Latch start address = (cfg_trigger_pos - cfg_pretrigger) mod D. Wrapping subtraction in BRAM_ADDR_WIDTH bits.
    - Latch remaining = cfg_length.
    - If cfg_length=0, go to DONE.
    - Otherwise go to RUN, with bram_porta_addr loaded with the start address.
  - RUN: busy=1. Issue a read in a cycle iff all of the following hold:
    - remaining reads > 0;
    - (buffer occupancy + reads in flight - pop this cycle) < 2.
    On issue, the address increments by 1 modulo D (D-1 wraps to 0) and remaining reads decrements. When the last word has been handshaken, go to DONE.
  - DONE: done=1 for exactly one cycle, busy=0, then IDLE.
- start is ignored while in RUN or DONE. cfg_* are sampled only at the accepted start; later changes have no effect.
- Output buffer:
  - 2-entry FIFO; m_axis_tvalid = buffer non-empty; tdata comes from the buffer head.
  - tdata/tvalid/tlast are held stable while tvalid=1 and tready=0.
  - The BRAM is never read without buffer space, so no sample is dropped or duplicated.
- tlast: asserted with tvalid only on beat number cfg_length (the last). It is 0 on all other beats.
- Throughput and latency:
  - With tready held high, one beat per cycle sustained, no bubbles.
  - Latency: start accepted at edge E0 → first tvalid=1 after edge E2.
- Wrap-around: a packet may cross address D-1→0 any number of times within its length. With cfg_length=D, every address is read exactly once, starting at the start address.
- Width rules:
  - cfg_pretrigger > cfg_trigger_pos wraps modulo D. This is intended, not an error.
  - The beat counter is BRAM_ADDR_WIDTH+1 bits so that length D is representable.
- Simultaneous events:
  - Pop and push in the same cycle keep occupancy unchanged.
  - done is emitted in the cycle after the last handshake, even if start is already high. That start is accepted in IDLE on the following edge.

Test Plan:
- D=1024, trigger_pos=100, pretrigger=10, length=20, tready=1, BRAM[a]=a → addresses 90..109, tdata 90..109 on consecutive cycles, tlast on 109, first tvalid 2 clocks after start, done pulse once.
- trigger_pos=5, pretrigger=10, length=16 → start address 1019; tdata 1019..1023, 0..10, tlast on 10.
- length=1024, pretrigger=0, trigger_pos=512 → 1024 beats, 512..1023 then 0..511, each exactly once, tlast only on 511.
- Random tready (~50% duty), length=64 → stream identical to the tready=1 case, and tdata stable while stalled.
- length=0 → no tvalid, busy stays 0, done pulses 1 cycle after start.
- aresetn low at beat 7 of 20, then start again → outputs 0 immediately; new packet is complete and correct; no stale beat from the aborted run appears.

Source files
------------

// File: rtl/axis_circular_unpacker_if.sv
// AXI4-Stream master bus carrying the unpacked capture samples.
// The master drives data/valid/last; the slave drives ready.
interface axis_circular_unpacker_if #(
  parameter int DW = 32
) ();
  logic [DW-1:0] tdata;
  logic          tvalid;
  logic          tready;
  logic          tlast;

  modport master (output tdata, output tvalid, output tlast, input tready);
  modport slave  (input tdata, input tvalid, input tlast, output tready);
endinterface

// File: rtl/axis_circular_unpacker.sv
// Reads the circular capture BRAM oldest-first after a capture stops and
// streams the samples out as one AXI4-Stream packet through a 2-deep skid FIFO.
module axis_circular_unpacker #(
  parameter int AXIS_TDATA_WIDTH = 32,
  parameter int BRAM_DATA_WIDTH  = 32,
  parameter int BRAM_ADDR_WIDTH  = 10
) (
  input  logic                       aclk,
  input  logic                       aresetn,
  input  logic [BRAM_ADDR_WIDTH-1:0] cfg_trigger_pos,
  input  logic [BRAM_ADDR_WIDTH-1:0] cfg_pretrigger,
  input  logic [BRAM_ADDR_WIDTH:0]   cfg_length,
  input  logic                       start,
  output logic                       busy,
  output logic                       done,
  output logic                       bram_porta_clk,
  output logic                       bram_porta_rst,
  output logic [BRAM_ADDR_WIDTH-1:0] bram_porta_addr,
  input  logic [BRAM_DATA_WIDTH-1:0] bram_porta_rddata,
  axis_circular_unpacker_if.master   m_axis
);
  localparam int AW = BRAM_ADDR_WIDTH;
  localparam int DW = AXIS_TDATA_WIDTH;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t              r_state;
  logic [AW-1:0]       r_addr;
  logic [AW:0]         r_rem;
  logic                r_infl;
  logic                r_infl_last;
  logic [1:0][DW-1:0]  r_buf;
  logic [1:0]          r_blast;
  logic                r_wp;
  logic                r_rp;
  logic [1:0]          r_cnt;
  logic                r_busy;
  logic                r_done;

  logic                w_pop;
  logic [2:0]          w_occ;
  logic                w_issue;
  logic [AW-1:0]       w_start_addr;

  assign bram_porta_clk  = aclk;
  assign bram_porta_rst  = ~aresetn;
  assign bram_porta_addr = r_addr;
  assign busy            = r_busy;
  assign done            = r_done;

  assign m_axis.tvalid = (r_cnt != 2'd0);
  assign m_axis.tdata  = r_buf[r_rp];
  assign m_axis.tlast  = (r_cnt != 2'd0) && r_blast[r_rp];

  assign w_pop        = m_axis.tvalid && m_axis.tready;
  assign w_start_addr = cfg_trigger_pos - cfg_pretrigger;
  // Count the read already in flight so the FIFO can never be overrun.
  assign w_occ   = {1'b0, r_cnt} + {2'b00, r_infl} - {2'b00, w_pop};
  assign w_issue = (r_state == S_RUN) && (r_rem != '0) && (w_occ < 3'd2);

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_infl      <= 1'b0;
      r_infl_last <= 1'b0;
      r_buf       <= '0;
      r_blast     <= '0;
      r_wp        <= 1'b0;
      r_rp        <= 1'b0;
      r_cnt       <= 2'd0;
    end else begin
      r_infl      <= w_issue;
      r_infl_last <= w_issue && (r_rem == (AW+1)'(1));
      if (r_infl) begin
        r_buf[r_wp]   <= bram_porta_rddata;
        r_blast[r_wp] <= r_infl_last;
        r_wp          <= ~r_wp;
      end
      if (w_pop) r_rp <= ~r_rp;
      r_cnt <= r_cnt + {1'b0, r_infl} - {1'b0, w_pop};
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_state <= S_IDLE;
      r_addr  <= '0;
      r_rem   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_done <= 1'b0;
          if (start) begin
            r_rem <= cfg_length;
            if (cfg_length == '0) begin
              r_state <= S_DONE;
              r_done  <= 1'b1;
            end else begin
              r_addr  <= w_start_addr;
              r_state <= S_RUN;
              r_busy  <= 1'b1;
            end
          end
        end
        S_RUN: begin
          if (w_issue) begin
            r_addr <= r_addr + AW'(1);
            r_rem  <= r_rem - (AW+1)'(1);
          end
          if (w_pop && r_blast[r_rp]) begin
            r_state <= S_DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end
        end
        S_DONE: begin
          r_done  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end
endmodule
